// File: rtl/ex_pkg.sv
// Shared widths, stall encodings, opcode constants and the decode-to-execute
// bus layout for the MIPS execute stage.
package ex_pkg;

    localparam int ID_TO_EX_WD  = 173;
    localparam int EX_TO_MEM_WD = 143;
    localparam int EX_TO_ID_WD  = 38;
    localparam int STALL_BUS_WD = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam int   STALL_EX  = 2;
    localparam int   STALL_MEM = 3;

    // One-hot alu_op bit positions, add in the MSB down to lui in the LSB
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [13:0] sl_bus;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider: one quotient bit per cycle, signs applied on
// the magnitudes at the end, result held in DONE until EX is released.
module div
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, op1_q, op1_d;
    logic        negq_q, negq_d, negr_q, negr_d, zero_q, zero_d;
    logic [32:0] trial;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            op1_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            op1_q   <= op1_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        op1_d   = op1_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder
        trial   = {rem_q, quo_q[31]};
        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = DIV_BUSY;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = (signed_div && op1[31]) ? neg32(op1) : op1;
                    dvs_d   = (signed_div && op2[31]) ? neg32(op2) : op2;
                    op1_d   = op1;
                    negq_d  = signed_div && (op1[31] ^ op2[31]);
                    negr_d  = signed_div && op1[31];
                    zero_d  = (op2 == 32'd0);
                end
            end
            DIV_BUSY: begin
                if (trial >= {1'b0, dvs_q}) begin
                    rem_d = trial[31:0] - dvs_q;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (!hold) begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    assign busy      = (state_q == DIV_BUSY);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = zero_q ? 32'hFFFF_FFFF : (negq_q ? neg32(quo_q) : quo_q);
    assign remainder = zero_q ? op1_q : (negr_q ? neg32(rem_q) : rem_q);

endmodule

// File: rtl/ex.sv
// Execute stage: latches the decode bus, runs the ALU, single-cycle multiply
// and the multi-cycle divider, and drives the data SRAM request.
module ex
    import ex_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
    output logic                    loading,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    id_ex_t ex_q, ex_d;

    always_comb begin
        ex_d = ex_q;
        if (stall[STALL_EX] == NO_STOP)       ex_d = id_ex_t'(id_to_ex_bus);
        else if (stall[STALL_MEM] == NO_STOP) ex_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    logic [31:0] src1, src2, alu_res;
    logic [4:0]  sh;

    always_comb begin
        src1 = ({32{ex_q.sel_src1[0]}} & ex_q.rdata1)
             | ({32{ex_q.sel_src1[1]}} & ex_q.pc)
             | ({32{ex_q.sel_src1[2]}} & {27'b0, ex_q.inst[10:6]});
        src2 = ({32{ex_q.sel_src2[0]}} & ex_q.rdata2)
             | ({32{ex_q.sel_src2[1]}} & {{16{ex_q.inst[15]}}, ex_q.inst[15:0]})
             | ({32{ex_q.sel_src2[2]}} & 32'd8)
             | ({32{ex_q.sel_src2[3]}} & {16'b0, ex_q.inst[15:0]});
        sh      = src1[4:0];
        alu_res = '0;
        if (ex_q.alu_op[ALU_ADD])  alu_res |= src1 + src2;
        if (ex_q.alu_op[ALU_SUB])  alu_res |= src1 - src2;
        if (ex_q.alu_op[ALU_SLT])  alu_res |= {31'b0, $signed(src1) < $signed(src2)};
        if (ex_q.alu_op[ALU_SLTU]) alu_res |= {31'b0, src1 < src2};
        if (ex_q.alu_op[ALU_AND])  alu_res |= src1 & src2;
        if (ex_q.alu_op[ALU_NOR])  alu_res |= ~(src1 | src2);
        if (ex_q.alu_op[ALU_OR])   alu_res |= src1 | src2;
        if (ex_q.alu_op[ALU_XOR])  alu_res |= src1 ^ src2;
        if (ex_q.alu_op[ALU_SLL])  alu_res |= src2 << sh;
        if (ex_q.alu_op[ALU_SRL])  alu_res |= src2 >> sh;
        if (ex_q.alu_op[ALU_SRA])  alu_res |= 32'($signed(src2) >>> sh);
        if (ex_q.alu_op[ALU_LUI])  alu_res |= {src2[15:0], 16'b0};
    end

    logic [5:0]  funct;
    logic        is_special, is_mult, is_div, mul_signed;
    logic [63:0] prod;
    logic        div_busy, div_done;
    logic [31:0] div_quo, div_rem;

    assign funct      = ex_q.inst[5:0];
    assign is_special = (ex_q.inst[31:26] == 6'b0);
    assign is_mult    = is_special && (funct == FN_MULT || funct == FN_MULTU);
    assign is_div     = is_special && (funct == FN_DIV  || funct == FN_DIVU);
    assign mul_signed = (funct == FN_MULT);

    // Sign-extending to 64 bits lets one unsigned multiplier serve mult and multu
    assign prod = {{32{mul_signed & ex_q.rdata1[31]}}, ex_q.rdata1}
                * {{32{mul_signed & ex_q.rdata2[31]}}, ex_q.rdata2};

    div u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (is_div),
        .signed_div (funct == FN_DIV),
        .op1        (ex_q.rdata1),
        .op2        (ex_q.rdata2),
        .hold       (stall[STALL_EX]),
        .busy       (div_busy),
        .done       (div_done),
        .quotient   (div_quo),
        .remainder  (div_rem)
    );

    assign stallreq_for_ex = div_busy | (is_div & ~div_busy & ~div_done);

    logic        hilo_we;
    logic [31:0] hi, lo;

    always_comb begin
        hilo_we = 1'b0;
        hi      = '0;
        lo      = '0;
        if (is_mult) begin
            hilo_we = 1'b1;
            hi      = prod[63:32];
            lo      = prod[31:0];
        end else if (is_div && div_done) begin
            hilo_we = 1'b1;
            hi      = div_rem;
            lo      = div_quo;
        end
    end

    assign ex_to_mem_bus   = {hilo_we, hi, lo, ex_q.sl_bus, ex_q.pc, alu_res};
    assign ex_to_id_bus    = {ex_q.rf_we, ex_q.rf_waddr, alu_res};
    assign loading         = ex_q.sl_bus[13];
    assign data_sram_en    = ex_q.data_ram_en;
    assign data_sram_wen   = ex_q.data_ram_wen;
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = ex_q.rdata2;

    logic unused_bits;
    assign unused_bits = ^{ex_q.inst[25:16], ex_q.sel_rf_res, stall[5:4], stall[1:0]};

endmodule
